// File: rtl/pwm_capture.sv
// PWM capture: synchronizes an async PWM input and measures high time and
// period (rise to rise) in clk cycles, with a stuck timeout for constant input.
module pwm_capture #(
    parameter int CNT_W = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] duty,
    output logic [CNT_W-1:0] period,
    output logic             valid,
    output logic             stuck
);

    typedef enum logic {
        IDLE,
        MEASURE
    } state_t;

    localparam logic [CNT_W-1:0] MAX  = '1;
    localparam logic [CNT_W-1:0] ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] ZERO = '0;

    state_t           state;
    logic             s_meta;
    logic             s;
    logic             s_d;
    logic             rise;
    logic             at_max;
    logic [CNT_W-1:0] per_cnt;
    logic [CNT_W-1:0] hi_cnt;
    logic [CNT_W-1:0] hi_inc;

    assign rise   = s & ~s_d;
    assign at_max = (per_cnt == MAX);
    assign hi_inc = {{(CNT_W-1){1'b0}}, s};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s_meta <= 1'b0;
            s      <= 1'b0;
            s_d    <= 1'b0;
        end else begin
            s_meta <= pwm_in;
            s      <= s_meta;
            s_d    <= s;
        end
    end

    // A rise always wins over the timeout, so a period of exactly MAX
    // still reports as a normal measurement.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            per_cnt <= ZERO;
            hi_cnt  <= ZERO;
            duty    <= ZERO;
            period  <= ZERO;
            valid   <= 1'b0;
            stuck   <= 1'b0;
        end else begin
            valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (rise) begin
                        state   <= MEASURE;
                        per_cnt <= ONE;
                        hi_cnt  <= ONE;
                    end else if (at_max) begin
                        valid   <= 1'b1;
                        stuck   <= 1'b1;
                        period  <= MAX;
                        duty    <= s ? MAX : ZERO;
                        per_cnt <= ZERO;
                    end else begin
                        per_cnt <= per_cnt + ONE;
                    end
                end
                MEASURE: begin
                    if (rise) begin
                        valid   <= 1'b1;
                        stuck   <= 1'b0;
                        period  <= per_cnt;
                        duty    <= hi_cnt;
                        per_cnt <= ONE;
                        hi_cnt  <= ONE;
                    end else if (at_max) begin
                        valid   <= 1'b1;
                        stuck   <= 1'b1;
                        period  <= MAX;
                        duty    <= s ? MAX : ZERO;
                        state   <= IDLE;
                        per_cnt <= ZERO;
                    end else begin
                        per_cnt <= per_cnt + ONE;
                        hi_cnt  <= hi_cnt + hi_inc;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: a bench-owned PWM generator drives the
// input and each reported result is compared against hand-computed values.
module tb_pwm_capture;

    logic       clk;
    logic       rst_n;
    logic       pwm_in;
    logic [9:0] duty;
    logic [9:0] period;
    logic       valid;
    logic       stuck;

    int errors;
    int checks;
    int cyc;
    int last_cyc;
    int prev_cyc;

    // generator control (main process writes, generator reads)
    int pend_p;
    int pend_h;
    bit pend_restart;
    int req_id;
    bit use_level;
    bit level;
    // generator state (generator process only)
    int gen_p;
    int gen_h;
    int gen_cnt;
    int ack_id;

    pwm_capture #(.CNT_W(10)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .pwm_in (pwm_in),
        .duty   (duty),
        .period (period),
        .valid  (valid),
        .stuck  (stuck)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        gen_p   = 256;
        gen_h   = 64;
        gen_cnt = 0;
        ack_id  = 0;
        pwm_in  = 1'b0;
    end

    // Parameter changes land on a period wrap unless a restart is requested.
    always @(negedge clk) begin
        if (use_level) begin
            pwm_in = level;
        end else begin
            if (req_id != ack_id && pend_restart) begin
                gen_p   = pend_p;
                gen_h   = pend_h;
                gen_cnt = 0;
                ack_id  = req_id;
            end else if (gen_cnt >= gen_p - 1) begin
                gen_cnt = 0;
                if (req_id != ack_id) begin
                    gen_p  = pend_p;
                    gen_h  = pend_h;
                    ack_id = req_id;
                end
            end else begin
                gen_cnt = gen_cnt + 1;
            end
            pwm_in = (gen_cnt < gen_h);
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic wait_valid(input string tag, input int maxc);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            @(posedge clk);
            #1;
            if (valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check({tag, "_timeout"}, 0, 1);
        prev_cyc = last_cyc;
        last_cyc = cyc;
    endtask

    task automatic gen_set(input int p, input int h, input bit restart);
        bit ok;
        pend_p       = p;
        pend_h       = h;
        pend_restart = restart;
        req_id       = req_id + 1;
        ok           = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            #1;
            if (ack_id == req_id) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("gen_ack_timeout", 0, 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic expect_res(input string tag, input int d, input int p, input int st);
        check({tag, "_duty"}, int'(duty), d);
        check({tag, "_period"}, int'(period), p);
        check({tag, "_stuck"}, int'(stuck), st);
    endtask

    initial begin
        errors       = 0;
        checks       = 0;
        last_cyc     = 0;
        prev_cyc     = 0;
        req_id       = 0;
        pend_p       = 256;
        pend_h       = 64;
        pend_restart = 1'b0;
        use_level    = 1'b0;
        level        = 1'b0;
        rst_n        = 1'b0;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_duty", int'(duty), 0);
        check("rst_period", int'(period), 0);
        check("rst_valid", int'(valid), 0);
        check("rst_stuck", int'(stuck), 0);

        // 1: 64/256 from the generator
        @(negedge clk);
        rst_n = 1'b1;
        gen_set(256, 64, 1'b1);
        wait_valid("t1a", 1200);
        expect_res("t1a", 64, 256, 0);
        wait_valid("t1b", 400);
        expect_res("t1b", 64, 256, 0);
        check("t1_interval", last_cyc - prev_cyc, 256);

        // 2: constant low
        use_level = 1'b1;
        level     = 1'b0;
        do_reset();
        wait_valid("t2a", 1200);
        expect_res("t2a", 0, 1023, 1);
        wait_valid("t2b", 1200);
        expect_res("t2b", 0, 1023, 1);
        check("t2_interval", last_cyc - prev_cyc, 1024);

        // 3: single rise, then held high
        level = 1'b1;
        wait_valid("t3a", 1200);
        expect_res("t3a", 1023, 1023, 1);
        check("t3_delay_ok", int'((last_cyc - prev_cyc) >= 1024 &&
                                  (last_cyc - prev_cyc) <= 1028), 1);
        wait_valid("t3b", 1200);
        expect_res("t3b", 1023, 1023, 1);
        check("t3_interval", last_cyc - prev_cyc, 1024);

        // 4: minimum period, step to 2/3, then period exactly MAX
        use_level = 1'b0;
        do_reset();
        gen_set(2, 1, 1'b1);
        wait_valid("t4a", 50);
        expect_res("t4a", 1, 2, 0);
        wait_valid("t4b", 10);
        expect_res("t4b", 1, 2, 0);
        check("t4_int2", last_cyc - prev_cyc, 2);
        gen_set(3, 2, 1'b0);
        repeat (8) @(posedge clk);
        wait_valid("t4c", 10);
        expect_res("t4c", 2, 3, 0);
        wait_valid("t4d", 10);
        expect_res("t4d", 2, 3, 0);
        check("t4_int3", last_cyc - prev_cyc, 3);
        gen_set(1023, 1, 1'b0);
        repeat (20) @(posedge clk);
        wait_valid("t4e", 1200);
        expect_res("t4e", 1, 1023, 0);
        wait_valid("t4f", 1200);
        expect_res("t4f", 1, 1023, 0);
        check("t4_int1023", last_cyc - prev_cyc, 1023);

        // 5: one-cycle reset mid-period
        do_reset();
        gen_set(256, 64, 1'b1);
        wait_valid("t5a", 1200);
        expect_res("t5a", 64, 256, 0);
        repeat (100) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("t5_rst_duty", int'(duty), 0);
        check("t5_rst_period", int'(period), 0);
        check("t5_rst_valid", int'(valid), 0);
        @(negedge clk);
        rst_n    = 1'b1;
        last_cyc = cyc;
        wait_valid("t5b", 1200);
        expect_res("t5b", 64, 256, 0);
        check("t5_no_early", int'((last_cyc - prev_cyc) > 256), 1);

        // 6: duty step at the generator wrap
        gen_set(256, 200, 1'b0);
        wait_valid("t6a", 400);
        expect_res("t6a", 64, 256, 0);
        wait_valid("t6b", 400);
        expect_res("t6b", 200, 256, 0);
        wait_valid("t6c", 400);
        expect_res("t6c", 200, 256, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
